// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle: CPU side, DMA side and the DMEM macro side.
// The slave modport belongs to the arbiter, master to the environment.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              Cpu_En;
  logic              Cpu_WrEn;
  logic [ADDR_W-1:0] Cpu_Addr;
  logic [DATA_W-1:0] Cpu_Wr_Data;
  logic [DATA_W-1:0] Cpu_Rd_Data;
  logic              Cpu_Stall;

  logic              Dma_Req;
  logic              Dma_WrEn;
  logic [ADDR_W-1:0] Dma_Addr;
  logic [DATA_W-1:0] Dma_Wr_Data;
  logic              Dma_Gnt;
  logic [DATA_W-1:0] Dma_Rd_Data;
  logic              Dma_Rd_Valid;
  logic [15:0]       Force_Cnt;

  logic              Mem_En;
  logic              Mem_WrEn;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Wr_Data;
  logic [DATA_W-1:0] Mem_Rd_Data;

  modport slave (
    input  Cpu_En, Cpu_WrEn, Cpu_Addr, Cpu_Wr_Data,
    output Cpu_Rd_Data, Cpu_Stall,
    input  Dma_Req, Dma_WrEn, Dma_Addr, Dma_Wr_Data,
    output Dma_Gnt, Dma_Rd_Data, Dma_Rd_Valid, Force_Cnt,
    output Mem_En, Mem_WrEn, Mem_Addr, Mem_Wr_Data,
    input  Mem_Rd_Data
  );

  modport master (
    output Cpu_En, Cpu_WrEn, Cpu_Addr, Cpu_Wr_Data,
    input  Cpu_Rd_Data, Cpu_Stall,
    output Dma_Req, Dma_WrEn, Dma_Addr, Dma_Wr_Data,
    input  Dma_Gnt, Dma_Rd_Data, Dma_Rd_Valid, Force_Cnt,
    input  Mem_En, Mem_WrEn, Mem_Addr, Mem_Wr_Data,
    output Mem_Rd_Data
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// CPU-priority arbiter for the shared DMEM port with a DMA starvation
// guard; read data is steered back to whichever side issued the read.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  dmem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        r_starve_cnt;
  owner_e            r_rd_owner;
  logic [DATA_W-1:0] r_cpu_hold;
  logic [DATA_W-1:0] r_dma_rd_data;
  logic              r_dma_rd_valid;
  logic [15:0]       r_force_cnt;

  logic w_force;
  logic w_cpu_sel;
  logic w_dma_sel;

  always_comb begin
    w_force   = bus.Dma_Req && (r_starve_cnt == LIMIT);
    w_cpu_sel = !Reset && bus.Cpu_En && !w_force;
    w_dma_sel = !Reset && bus.Dma_Req &&
                (!bus.Cpu_En || w_force);
  end

  always_comb begin
    bus.Mem_En      = w_cpu_sel || w_dma_sel;
    bus.Mem_WrEn    = 1'b0;
    bus.Mem_Addr    = bus.Cpu_Addr;
    bus.Mem_Wr_Data = bus.Cpu_Wr_Data;
    if (w_dma_sel) begin
      bus.Mem_WrEn    = bus.Dma_WrEn;
      bus.Mem_Addr    = bus.Dma_Addr;
      bus.Mem_Wr_Data = bus.Dma_Wr_Data;
    end else if (w_cpu_sel) begin
      bus.Mem_WrEn    = bus.Cpu_WrEn;
    end
  end

  always_comb begin
    bus.Dma_Gnt   = w_dma_sel;
    bus.Cpu_Stall = !Reset && bus.Cpu_En && w_force;
    bus.Cpu_Rd_Data = (r_rd_owner == OWN_CPU) ?
                      bus.Mem_Rd_Data : r_cpu_hold;
  end

  assign bus.Dma_Rd_Data  = r_dma_rd_data;
  assign bus.Dma_Rd_Valid = r_dma_rd_valid;
  assign bus.Force_Cnt    = r_force_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_starve_cnt   <= '0;
      r_rd_owner     <= OWN_NONE;
      r_cpu_hold     <= '0;
      r_dma_rd_data  <= '0;
      r_dma_rd_valid <= 1'b0;
      r_force_cnt    <= '0;
    end else begin
      if (!bus.Dma_Req || w_dma_sel)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != LIMIT)
        r_starve_cnt <= r_starve_cnt + 4'd1;

      if (w_force && bus.Cpu_En && r_force_cnt != 16'hFFFF)
        r_force_cnt <= r_force_cnt + 16'd1;

      unique case (1'b1)
        w_cpu_sel && !bus.Cpu_WrEn: r_rd_owner <= OWN_CPU;
        w_dma_sel && !bus.Dma_WrEn: r_rd_owner <= OWN_DMA;
        default:                    r_rd_owner <= OWN_NONE;
      endcase

      if (r_rd_owner == OWN_CPU)
        r_cpu_hold <= bus.Mem_Rd_Data;

      // DMA data is registered here, hence the 2-cycle DMA read latency
      r_dma_rd_valid <= (r_rd_owner == OWN_DMA);
      if (r_rd_owner == OWN_DMA)
        r_dma_rd_data <= bus.Mem_Rd_Data;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 1-cycle-latency DMEM model.
// Inputs change just after the rising edge; outputs are sampled mid-cycle.
module tb_dmem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 64;

  logic Clock = 1'b0;
  logic Reset;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 Clock = ~Clock;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  logic [DW-1:0] mem [256];

  always @(posedge Clock) begin
    if (bus.Mem_En && bus.Mem_WrEn)
      mem[bus.Mem_Addr] <= bus.Mem_Wr_Data;
    bus.Mem_Rd_Data <= (bus.Mem_En && !bus.Mem_WrEn) ?
                       mem[bus.Mem_Addr] : 64'hDEAD;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic mid();
    @(negedge Clock);
  endtask

  task automatic idle();
    bus.Cpu_En      = 1'b0;
    bus.Cpu_WrEn    = 1'b0;
    bus.Cpu_Addr    = '0;
    bus.Cpu_Wr_Data = '0;
    bus.Dma_Req     = 1'b0;
    bus.Dma_WrEn    = 1'b0;
    bus.Dma_Addr    = '0;
    bus.Dma_Wr_Data = '0;
  endtask

  task automatic cpu(input logic wr, input logic [7:0] a,
                     input logic [63:0] d);
    bus.Cpu_En      = 1'b1;
    bus.Cpu_WrEn    = wr;
    bus.Cpu_Addr    = a;
    bus.Cpu_Wr_Data = d;
  endtask

  task automatic dma(input logic wr, input logic [7:0] a,
                     input logic [63:0] d);
    bus.Dma_Req     = 1'b1;
    bus.Dma_WrEn    = wr;
    bus.Dma_Addr    = a;
    bus.Dma_Wr_Data = d;
  endtask

  task automatic contend(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      idle();
      cpu(1'b0, 8'h30, '0);
      dma(1'b0, 8'h31, '0);
      mid();
      chk("ct_gnt", 64'(bus.Dma_Gnt), 64'(k % 5 == 4));
      chk("ct_stall", 64'(bus.Cpu_Stall), 64'(k % 5 == 4));
      chk("ct_addr", 64'(bus.Mem_Addr),
          (k % 5 == 4) ? 64'h31 : 64'h30);
      tick();
      if (k % 5 == 4) begin
        if (base == 16'hFFFE)
          chk("sat_cnt", 64'(bus.Force_Cnt), 64'hFFFF);
        else
          chk("ct_fcnt", 64'(bus.Force_Cnt),
              64'(base + 16'((k + 1) / 5)));
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    cpu(1'b1, 8'h10, 64'hA5);
    dma(1'b0, 8'h20, '0);
    mid();
    chk("rst_mem_en", 64'(bus.Mem_En), 0);
    chk("rst_wren", 64'(bus.Mem_WrEn), 0);
    chk("rst_gnt", 64'(bus.Dma_Gnt), 0);
    chk("rst_stall", 64'(bus.Cpu_Stall), 0);
    tick();
    tick();
    Reset = 1'b0;
    idle();
    chk("rst_fcnt", 64'(bus.Force_Cnt), 0);
    chk("rst_valid", 64'(bus.Dma_Rd_Valid), 0);
    chk("rst_dma_data", bus.Dma_Rd_Data, 0);
    chk("rst_cpu_data", bus.Cpu_Rd_Data, 0);

    // preload memory through the CPU path
    cpu(1'b1, 8'h20, 64'h1234); tick();
    cpu(1'b1, 8'h01, 64'h11);   tick();
    cpu(1'b1, 8'h02, 64'h22);   tick();

    // CPU write then read
    cpu(1'b1, 8'h10, 64'hA5);
    mid();
    chk("c_wr_en", 64'(bus.Mem_En), 1);
    chk("c_wr_we", 64'(bus.Mem_WrEn), 1);
    chk("c_wr_addr", 64'(bus.Mem_Addr), 64'h10);
    chk("c_wr_stall", 64'(bus.Cpu_Stall), 0);
    tick();
    cpu(1'b0, 8'h10, '0);
    mid();
    chk("c_rd_en", 64'(bus.Mem_En), 1);
    chk("c_rd_we", 64'(bus.Mem_WrEn), 0);
    chk("c_rd_stall", 64'(bus.Cpu_Stall), 0);
    tick();
    idle();
    mid();
    chk("c_rd_data", bus.Cpu_Rd_Data, 64'hA5);
    tick();
    mid();
    chk("c_hold", bus.Cpu_Rd_Data, 64'hA5);
    tick();

    // DMA-only read: valid two cycles after grant
    dma(1'b0, 8'h20, '0);
    mid();
    chk("d_gnt", 64'(bus.Dma_Gnt), 1);
    chk("d_addr", 64'(bus.Mem_Addr), 64'h20);
    tick();
    idle();
    chk("d_valid_early", 64'(bus.Dma_Rd_Valid), 0);
    tick();
    chk("d_valid", 64'(bus.Dma_Rd_Valid), 1);
    chk("d_data", bus.Dma_Rd_Data, 64'h1234);
    tick();
    chk("d_valid_pulse", 64'(bus.Dma_Rd_Valid), 0);

    // continuous contention: forced slot every 5th cycle
    contend(10, 16'h0);
    idle();
    tick();

    // interleaved reads, CPU forced behind DMA
    for (int k = 0; k < 6; k++) begin
      idle();
      cpu(1'b0, 8'h01, '0);
      if (k <= 4) dma(1'b0, 8'h02, '0);
      mid();
      if (k == 4) begin
        chk("il_gnt", 64'(bus.Dma_Gnt), 1);
        chk("il_stall", 64'(bus.Cpu_Stall), 1);
        chk("il_addr", 64'(bus.Mem_Addr), 64'h02);
      end
      if (k == 5) begin
        chk("il_cpu_gnt", 64'(bus.Dma_Gnt), 0);
        chk("il_cpu_hold", bus.Cpu_Rd_Data, 64'h11);
      end
      tick();
      if (k == 4) chk("il_valid_early", 64'(bus.Dma_Rd_Valid), 0);
      if (k == 5) begin
        chk("il_valid", 64'(bus.Dma_Rd_Valid), 1);
        chk("il_dma_data", bus.Dma_Rd_Data, 64'h22);
      end
    end
    idle();
    mid();
    chk("il_cpu_data", bus.Cpu_Rd_Data, 64'h11);
    tick();
    chk("il_fcnt", 64'(bus.Force_Cnt), 3);

    // reset between DMA read grant and its return
    dma(1'b0, 8'h20, '0);
    mid();
    chk("r_gnt", 64'(bus.Dma_Gnt), 1);
    tick();
    Reset = 1'b1;
    cpu(1'b1, 8'h40, 64'h99);
    mid();
    chk("r_mem_en", 64'(bus.Mem_En), 0);
    chk("r_gnt_low", 64'(bus.Dma_Gnt), 0);
    chk("r_stall", 64'(bus.Cpu_Stall), 0);
    tick();
    Reset = 1'b0;
    idle();
    chk("r_valid", 64'(bus.Dma_Rd_Valid), 0);
    chk("r_dma_data", bus.Dma_Rd_Data, 0);
    chk("r_fcnt", 64'(bus.Force_Cnt), 0);
    chk("r_cpu_hold", bus.Cpu_Rd_Data, 0);
    tick();
    chk("r_valid_late", 64'(bus.Dma_Rd_Valid), 0);

    // Force_Cnt saturation from a preloaded count
    force dut.r_force_cnt = 16'hFFFE;
    #1;
    release dut.r_force_cnt;
    chk("sat_pre", 64'(bus.Force_Cnt), 64'hFFFE);
    contend(10, 16'hFFFE);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
